// File: rtl/overlap_accum_seq.sv
// overlap_accum_seq
// Overlap recombination stage for the GF(2) Karatsuba multiplier datapath.
// Collects the three sub-products (L, M, Hi) of an N-bit split carry-less
// multiplication as a stream of beats, XOR-accumulates each at its overlap
// offset, and holds the (2N-1)-bit product on a valid/ready output.
//
// MODE 0: middle term arrives already corrected and is placed as given.
// MODE 1: middle term is raw (aL^aH)*(bL^bH); the L^Hi correction is folded
//         in by also placing L and Hi at offset H as they arrive.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_L    | collecting, next beat is the low sub-product (term_idx 0)
// ST_M    | collecting, next beat is the middle sub-product (term_idx 1)
// ST_HI   | collecting, next beat is the high sub-product (term_idx 2)
// ST_DONE | product held on out_data, waiting for out_ready

module overlap_accum_seq #(
    parameter int N    = 6,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-2:0]   in_term,
    output logic [1:0]     term_idx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] out_data
);

    localparam int H = N / 2;
    localparam int W = 2 * N - 1;
    localparam bit KARATSUBA = (MODE != 0);

    typedef enum logic [1:0] {
        ST_L    = 2'd0,
        ST_M    = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_next;
    logic [W-1:0]   term_ext;
    logic [W-1:0]   term_sh_h;
    logic [W-1:0]   term_sh_n;
    logic           accept;

    // Sub-product placements; anything shifted past bit 2N-2 is dropped by
    // the fixed accumulator width (never happens for legal degree <= N-2).
    always_comb begin
        term_ext  = {{N{1'b0}}, in_term};
        term_sh_h = term_ext << H;
        term_sh_n = term_ext << N;
    end

    // Handshake outputs come straight from registered state, so in_ready never
    // depends on out_ready and out_data has no path from in_term.
    always_comb begin
        in_ready  = (state != ST_DONE);
        out_valid = (state == ST_DONE);
        out_data  = acc;
        accept    = in_valid && (state != ST_DONE);
        case (state)
            ST_L:    term_idx = 2'd0;
            ST_M:    term_idx = 2'd1;
            ST_HI:   term_idx = 2'd2;
            default: term_idx = 2'd0;
        endcase
    end

    // Next-state and accumulator update; clr overrides both accept and the
    // output handshake and discards whatever was collected or held.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        case (state)
            ST_L: begin
                if (accept) begin
                    // Overwrite, never XOR: no stale bits from a prior product.
                    acc_next   = KARATSUBA ? (term_ext ^ term_sh_h) : term_ext;
                    state_next = ST_M;
                end
            end
            ST_M: begin
                if (accept) begin
                    acc_next   = acc ^ term_sh_h;
                    state_next = ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
                    acc_next   = KARATSUBA ? (acc ^ term_sh_h ^ term_sh_n)
                                           : (acc ^ term_sh_n);
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Return to L without accepting this cycle: 1-cycle bubble.
                if (out_ready) begin
                    state_next = ST_L;
                end
            end
            default: begin
                state_next = ST_L;
            end
        endcase
        if (clr) begin
            state_next = ST_L;
            acc_next   = '0;
        end
    end

    // State and accumulator registers; rst acts like clr with top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_L;
            acc   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
        end
    end

endmodule

// File: tb/tb_overlap_accum_seq.sv
// Bench for overlap_accum_seq: three instances (N=6 MODE 0, N=6 MODE 1,
// N=8 MODE 1) driven by directed steps; expected products are queued when a
// product's beats are driven and popped when the output handshake occurs.
module tb_overlap_accum_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clr_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [4:0]  in_term_a;
    logic [1:0]  term_idx_a;
    logic [10:0] out_data_a;

    logic        clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [4:0]  in_term_b;
    logic [1:0]  term_idx_b;
    logic [10:0] out_data_b;

    logic        clr_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
    logic [6:0]  in_term_c;
    logic [1:0]  term_idx_c;
    logic [14:0] out_data_c;

    overlap_accum_seq #(.N(6), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_term(in_term_a), .term_idx(term_idx_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a));

    overlap_accum_seq #(.N(6), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_term(in_term_b), .term_idx(term_idx_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b));

    overlap_accum_seq #(.N(8), .MODE(1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .in_term(in_term_c), .term_idx(term_idx_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c));

    int checks = 0;
    int errors = 0;

    logic [14:0] q_a[$];
    logic [14:0] q_b[$];
    logic [14:0] q_c[$];
    logic [14:0] exp_mon;

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry-less (GF(2)) multiply of the low w bits of a and b.
    function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < w; i++)
            if (b[i]) r = r ^ (15'(a) << i);
        return r;
    endfunction

    task automatic send_a(input logic [4:0] t);
        in_valid_a = 1'b1; in_term_a = t; tick(); in_valid_a = 1'b0;
    endtask
    task automatic send_b(input logic [4:0] t);
        in_valid_b = 1'b1; in_term_b = t; tick(); in_valid_b = 1'b0;
    endtask
    task automatic send_c(input logic [6:0] t);
        in_valid_c = 1'b1; in_term_c = t; tick(); in_valid_c = 1'b0;
    endtask

    // Scoreboard: every completed output handshake must match the oldest
    // queued expectation; a handshake with nothing queued is an error.
    always @(negedge clk) begin
        if (!rst && !clr_a && out_valid_a && out_ready_a) begin
            checks++;
            assert (q_a.size() > 0) else begin
                errors++;
                $error("FAIL sb_a_unexpected: observed %0h expected none", out_data_a);
            end
            if (q_a.size() > 0) begin
                exp_mon = q_a.pop_front();
                chk("sb_a_data", 15'(out_data_a), exp_mon);
            end
        end
        if (!rst && !clr_b && out_valid_b && out_ready_b) begin
            checks++;
            assert (q_b.size() > 0) else begin
                errors++;
                $error("FAIL sb_b_unexpected: observed %0h expected none", out_data_b);
            end
            if (q_b.size() > 0) begin
                exp_mon = q_b.pop_front();
                chk("sb_b_data", 15'(out_data_b), exp_mon);
            end
        end
        if (!rst && !clr_c && out_valid_c && out_ready_c) begin
            checks++;
            assert (q_c.size() > 0) else begin
                errors++;
                $error("FAIL sb_c_unexpected: observed %0h expected none", out_data_c);
            end
            if (q_c.size() > 0) begin
                exp_mon = q_c.pop_front();
                chk("sb_c_data", out_data_c, exp_mon);
            end
        end
    end

    initial begin
        logic [7:0] a, b;
        logic [3:0] al, ah, bl, bh;
        rst = 1'b1;
        clr_a = 0; in_valid_a = 0; in_term_a = '0; out_ready_a = 1;
        clr_b = 0; in_valid_b = 0; in_term_b = '0; out_ready_b = 1;
        clr_c = 0; in_valid_c = 0; in_term_c = '0; out_ready_c = 1;
        tick(); tick();

        // Reset values
        chk("rst_in_ready", 15'(in_ready_a), 15'd1);
        chk("rst_out_valid", 15'(out_valid_a), 15'd0);
        chk("rst_out_data", 15'(out_data_a), 15'd0);
        chk("rst_term_idx", 15'(term_idx_a), 15'd0);
        rst = 1'b0;
        tick();

        // MODE 0 basic product, then a beat offered during the bubble
        q_a.push_back(15'h0AD);
        send_a(5'h15); chk("t1_idx1", 15'(term_idx_a), 15'd1);
        send_a(5'h1F); chk("t1_idx2", 15'(term_idx_a), 15'd2);
        send_a(5'h01);
        chk("t1_out_valid", 15'(out_valid_a), 15'd1);
        chk("t1_in_ready", 15'(in_ready_a), 15'd0);
        chk("t1_term_idx", 15'(term_idx_a), 15'd0);
        chk("t1_out_data", 15'(out_data_a), 15'h0AD);
        in_valid_a = 1'b1; in_term_a = 5'h1B;
        tick();
        in_valid_a = 1'b0;
        chk("t1_valid_drop", 15'(out_valid_a), 15'd0);
        chk("t1_bubble_idx", 15'(term_idx_a), 15'd0);
        chk("t1_ready_back", 15'(in_ready_a), 15'd1);

        // MODE 1 with the same beats: middle corrected to 0x0B
        q_b.push_back(15'h00D);
        send_b(5'h15); send_b(5'h1F); send_b(5'h01);
        chk("t2_out_valid", 15'(out_valid_b), 15'd1);
        chk("t2_out_data", 15'(out_data_b), 15'h00D);
        tick();

        // Backpressure: result held stable for 5 cycles
        out_ready_a = 1'b0;
        q_a.push_back(15'h0AD);
        send_a(5'h15); send_a(5'h1F); send_a(5'h01);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 15'(out_valid_a), 15'd1);
            chk("t3_hold_data", 15'(out_data_a), 15'h0AD);
            chk("t3_hold_ready", 15'(in_ready_a), 15'd0);
            tick();
        end
        out_ready_a = 1'b1;
        chk("t3_still_valid", 15'(out_valid_a), 15'd1);
        tick();
        chk("t3_released", 15'(out_valid_a), 15'd0);
        chk("t3_in_ready", 15'(in_ready_a), 15'd1);

        // Idle gaps between beats
        q_a.push_back(15'h0AD);
        send_a(5'h15);
        repeat (3) tick();
        chk("t4_gap_idx1", 15'(term_idx_a), 15'd1);
        send_a(5'h1F);
        repeat (2) tick();
        chk("t4_gap_idx2", 15'(term_idx_a), 15'd2);
        send_a(5'h01);
        chk("t4_idx0", 15'(term_idx_a), 15'd0);
        chk("t4_data", 15'(out_data_a), 15'h0AD);
        tick();

        // Abort with clr mid-product; the same-cycle beat is ignored
        send_a(5'h1F); send_a(5'h1F);
        clr_a = 1'b1; in_valid_a = 1'b1; in_term_a = 5'h01;
        tick();
        clr_a = 1'b0; in_valid_a = 1'b0;
        chk("t5_clr_idx", 15'(term_idx_a), 15'd0);
        chk("t5_clr_valid", 15'(out_valid_a), 15'd0);
        chk("t5_clr_acc", 15'(out_data_a), 15'd0);
        q_a.push_back(15'h0AD);
        send_a(5'h15); send_a(5'h1F); send_a(5'h01);
        tick();

        // Abort with rst mid-product
        send_a(5'h1F); send_a(5'h1F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_idx", 15'(term_idx_a), 15'd0);
        q_a.push_back(15'h0AD);
        send_a(5'h15); send_a(5'h1F); send_a(5'h01);
        tick();

        // clr while DONE discards the held result
        out_ready_a = 1'b0;
        send_a(5'h15); send_a(5'h1F); send_a(5'h01);
        chk("t5_done_valid", 15'(out_valid_a), 15'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        out_ready_a = 1'b1;
        chk("t5_done_cleared", 15'(out_valid_a), 15'd0);
        chk("t5_done_data0", 15'(out_data_a), 15'd0);
        chk("t5_done_ready", 15'(in_ready_a), 15'd1);
        tick();

        // N=8 MODE 1, all beats 0x7F: L, raw M and Hi placed by the
        // accumulation rules give 0x7F ^ (0x7F<<4) ^ (0x7F<<8)
        q_c.push_back(15'h007F ^ 15'h07F0 ^ 15'h7F00);
        send_c(7'h7F); send_c(7'h7F); send_c(7'h7F);
        chk("t6_ones", out_data_c, 15'h788F);
        tick();

        // Random operand pairs against a full carry-less multiply
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            al = a[3:0]; ah = a[7:4]; bl = b[3:0]; bh = b[7:4];
            q_c.push_back(clmul(a, b, 8));
            send_c(7'(clmul({4'd0, al}, {4'd0, bl}, 4)));
            if ($urandom_range(0, 3) == 0) tick();
            send_c(7'(clmul({4'd0, al ^ ah}, {4'd0, bl ^ bh}, 4)));
            send_c(7'(clmul({4'd0, ah}, {4'd0, bh}, 4)));
            tick();
        end

        repeat (3) tick();
        chk("end_q_a_empty", 15'(q_a.size()), 15'd0);
        chk("end_q_b_empty", 15'(q_b.size()), 15'd0);
        chk("end_q_c_empty", 15'(q_c.size()), 15'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
